// File: rtl/sha256_round_core_if.sv
// Control and W_t stream bundle between the hash controller / message schedule
// (master) and the SHA-256 round core (slave).
interface sha256_round_core_if;
   logic         start;
   logic [255:0] hash_in;
   logic         w_valid;
   logic [31:0]  w_data;
   logic         w_ready;
   logic         busy;
   logic         done;
   logic [255:0] hash_out;

   modport master (
      output start, hash_in, w_valid, w_data,
      input  w_ready, busy, done, hash_out
   );

   modport slave (
      input  start, hash_in, w_valid, w_data,
      output w_ready, busy, done, hash_out
   );
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression: one round per accepted W_t, then a feed-forward add of
// the working variables into the saved chaining value.
module sha256_round_core #(
   parameter int NUM_ROUNDS = 64
) (
   input logic                clk,
   input logic                rst,
   sha256_round_core_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, y, z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, y, z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   state_t       state, state_nxt;
   logic [5:0]   cnt;
   logic [31:0]  wv [8];   // a..h, index 0 = a
   logic [31:0]  sh [8];   // chaining value saved for the feed-forward add
   logic [255:0] hash_q;
   logic         done_q;
   logic         start_ok;
   logic         hs;
   logic [31:0]  t1, t2;

   assign t1 = wv[7] + big_sig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + K_ROM[cnt] + bus.w_data;
   assign t2 = big_sig0(wv[0]) + maj(wv[0], wv[1], wv[2]);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      hs        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               start_ok  = 1'b1;
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            if (bus.w_valid) begin
               hs = 1'b1;
               if (cnt == LAST) state_nxt = FINAL;
            end
         end
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         done_q <= 1'b0;
         hash_q <= '0;
         for (int i = 0; i < 8; i++) begin
            wv[i] <= '0;
            sh[i] <= '0;
         end
      end else begin
         done_q <= (state == FINAL);
         if (start_ok) begin
            cnt <= '0;
            for (int i = 0; i < 8; i++) begin
               wv[i] <= bus.hash_in[255 - 32*i -: 32];
               sh[i] <= bus.hash_in[255 - 32*i -: 32];
            end
         end else if (hs) begin
            cnt   <= cnt + 6'd1;
            wv[7] <= wv[6];
            wv[6] <= wv[5];
            wv[5] <= wv[4];
            wv[4] <= wv[3] + t1;
            wv[3] <= wv[2];
            wv[2] <= wv[1];
            wv[1] <= wv[0];
            wv[0] <= t1 + t2;
         end
         // hash_out only moves on the FINAL edge, so it holds across the next block
         if (state == FINAL) begin
            for (int i = 0; i < 8; i++)
               hash_q[255 - 32*i -: 32] <= sh[i] + wv[i];
         end
      end
   end

   assign bus.w_ready  = (state == ROUND);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.hash_out = hash_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// Bench for sha256_round_core: known-answer digests, stalls, reset abandon,
// ignored start pulses and back-to-back blocks, checked through a digest queue.
module tb_sha256_round_core;
   typedef logic [31:0] blk_t   [16];
   typedef logic [31:0] sched_t [64];

   localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha256_round_core_if bus ();

   sha256_round_core #(.NUM_ROUNDS(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int           n_pass  = 0;
   int           n_total = 0;
   logic [255:0] exp_q [$];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic expand(input blk_t m, output sched_t w);
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
   endtask

   function automatic blk_t blk_abc();
      blk_t m;
      foreach (m[i]) m[i] = '0;
      m[0] = 32'h61626380; m[15] = 32'h00000018;
      return m;
   endfunction

   // Drives one block from a start pulse to done, leaving time in the done cycle.
   task automatic run_block(input logic [255:0] hin, input sched_t w, input int max_gap, input bit inj,
                            output int hs, output int lat, output logic [255:0] dig,
                            output bit to, output bit busy0, output bit hold_ok);
      logic [255:0] prev;
      int idx, gap;
      prev = bus.hash_out;
      hs = 0; lat = -1; dig = '0; to = 1'b1; hold_ok = 1'b1; idx = 0;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.start   = 1'b1;
      bus.hash_in = hin;
      bus.w_valid = 1'b1;
      bus.w_data  = $urandom;
      @(posedge clk); #1;
      busy0 = bus.busy;
      bus.hash_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int n = 0; n < 2000; n++) begin
         bus.start = 1'b0;
         if (bus.done) begin
            lat = n; dig = bus.hash_out; to = 1'b0;
            break;
         end
         if (bus.hash_out !== prev) hold_ok = 1'b0;
         if (inj && (idx == 20 || (idx == 64 && bus.busy && !bus.w_ready))) begin
            bus.start   = 1'b1;
            bus.hash_in = ~hin;
         end
         bus.w_data = $urandom;
         if (idx < 64) begin
            bus.w_valid = (gap == 0);
            if (gap == 0) bus.w_data = w[idx];
         end else begin
            bus.w_valid = 1'b1;
         end
         if (bus.w_valid && bus.w_ready) begin
            idx++; hs++;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         end else if (gap > 0) begin
            gap--;
         end
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
   endtask

   task automatic test_power_on();
      rst = 1'b1;
      bus.start = 1'b0; bus.hash_in = '0; bus.w_valid = 1'b0; bus.w_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL por_busy got=%b exp=0", bus.busy); else n_pass++;
      n_total++; if (bus.w_ready !== 1'b0) $display("FAIL por_w_ready got=%b exp=0", bus.w_ready); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL por_done got=%b exp=0", bus.done); else n_pass++;
      n_total++; if (bus.hash_out !== '0) $display("FAIL por_hash_out got=%h exp=0", bus.hash_out); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_empty();
      blk_t m; sched_t w; int hs, lat; logic [255:0] dig, exp; bit to, b0, hold;
      foreach (m[i]) m[i] = '0;
      m[0] = 32'h80000000;
      expand(m, w);
      exp_q.push_back(EMPTY_DIG);
      run_block(IV, w, 0, 1'b0, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (to) $display("FAIL empty_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL empty_digest got=%h exp=%h", dig, exp); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.done !== 1'b0) $display("FAIL empty_done_width got=%b exp=0", bus.done); else n_pass++;
   endtask

   task automatic test_reset();
      sched_t w; int hs, lat; logic [255:0] dig, exp; bit to, b0, hold, seen_done, seen_ready;
      expand(blk_abc(), w);
      bus.start = 1'b1; bus.hash_in = IV;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.w_valid = 1'b1; bus.w_data = w[i];
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
      n_total++; if (bus.w_ready !== 1'b0) $display("FAIL rst_w_ready got=%b exp=0", bus.w_ready); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.done); else n_pass++;
      n_total++; if (bus.hash_out !== '0) $display("FAIL rst_hash_out got=%h exp=0", bus.hash_out); else n_pass++;
      rst = 1'b0;
      seen_done = 1'b0; seen_ready = 1'b0;
      bus.w_valid = 1'b1;
      repeat (80) begin
         bus.w_data = $urandom;
         @(posedge clk); #1;
         if (bus.done) seen_done = 1'b1;
         if (bus.w_ready) seen_ready = 1'b1;
      end
      bus.w_valid = 1'b0;
      n_total++; if (seen_done) $display("FAIL rst_abandon_done got=1 exp=0"); else n_pass++;
      n_total++; if (seen_ready) $display("FAIL rst_idle_ready got=1 exp=0"); else n_pass++;
      exp_q.push_back(ABC_DIG);
      run_block(IV, w, 0, 1'b0, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (to) $display("FAIL rst_rerun_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL rst_rerun_digest got=%h exp=%h", dig, exp); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_abc();
      sched_t w; int hs, lat; logic [255:0] dig, exp; bit to, b0, hold;
      expand(blk_abc(), w);
      exp_q.push_back(ABC_DIG);
      run_block(IV, w, 0, 1'b0, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (to) $display("FAIL abc_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL abc_digest got=%h exp=%h", dig, exp); else n_pass++;
      n_total++; if (lat + 1 !== 66) $display("FAIL abc_latency got=%0d exp=66", lat + 1); else n_pass++;
      n_total++; if (hs !== 64) $display("FAIL abc_handshakes got=%0d exp=64", hs); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.done !== 1'b0) $display("FAIL abc_done_width got=%b exp=0", bus.done); else n_pass++;
   endtask

   task automatic test_stalls();
      sched_t w; int hs, lat; logic [255:0] dig, exp; bit to, b0, hold;
      expand(blk_abc(), w);
      exp_q.push_back(ABC_DIG);
      run_block(IV, w, 5, 1'b0, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (to) $display("FAIL stall_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL stall_digest got=%h exp=%h", dig, exp); else n_pass++;
      n_total++; if (hs !== 64) $display("FAIL stall_handshakes got=%0d exp=64", hs); else n_pass++;
      n_total++; if (!hold) $display("FAIL stall_hash_hold got=changed exp=held"); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.done !== 1'b0) $display("FAIL stall_done_width got=%b exp=0", bus.done); else n_pass++;
   endtask

   task automatic test_start_ignored();
      sched_t w; int hs, lat; logic [255:0] dig, exp; bit to, b0, hold;
      expand(blk_abc(), w);
      exp_q.push_back(ABC_DIG);
      run_block(IV, w, 0, 1'b1, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (to) $display("FAIL ign_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL ign_digest got=%h exp=%h", dig, exp); else n_pass++;
      n_total++; if (hs !== 64) $display("FAIL ign_handshakes got=%0d exp=64", hs); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL ign_no_restart got=%b exp=0", bus.busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      blk_t m1, m2; sched_t w1, w2; int hs, lat; logic [255:0] dig, exp, mid; bit to, b0, hold;
      m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
             32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      foreach (m2[i]) m2[i] = '0;
      m2[15] = 32'h000001c0;
      expand(m1, w1);
      expand(m2, w2);
      run_block(IV, w1, 0, 1'b0, hs, lat, dig, to, b0, hold);
      n_total++; if (to) $display("FAIL b2b_first_timeout got=no_done exp=done"); else n_pass++;
      // still in the done cycle: chain straight into the second block
      mid = bus.hash_out;
      exp_q.push_back(TWO_DIG);
      run_block(mid, w2, 0, 1'b0, hs, lat, dig, to, b0, hold);
      exp = exp_q.pop_front();
      n_total++; if (b0 !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", b0); else n_pass++;
      n_total++; if (to) $display("FAIL b2b_timeout got=no_done exp=done"); else n_pass++;
      n_total++; if (lat + 1 !== 66) $display("FAIL b2b_latency got=%0d exp=66", lat + 1); else n_pass++;
      n_total++; if (!hold) $display("FAIL b2b_hash_hold got=changed exp=held"); else n_pass++;
      n_total++; if (dig !== exp) $display("FAIL b2b_digest got=%h exp=%h", dig, exp); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.done !== 1'b0) $display("FAIL b2b_done_width got=%b exp=0", bus.done); else n_pass++;
   endtask

   initial begin
      test_power_on();
      test_empty();
      test_reset();
      test_abc();
      test_stalls();
      test_start_ignored();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
